// File: rtl/fsm_mealy_10101.sv
// fsm_mealy_10101: non-overlapping Mealy detector for the serial pattern 10101.
// data_out is combinational and is high while the bit that completes the
// pattern is on data_in. After a detection the machine restarts from S0.
// Optional build macro FSM10101_COUNT_EN adds det_count, a saturating
// detection counter of width CNT_W; without the macro the port and its logic
// are absent and detection behaviour is unchanged.
//
// state | meaning
// S0    | idle, no partial match
// S1    | seen "1"
// S2    | seen "10"
// S3    | seen "101"
// S4    | seen "1010", a 1 now completes the pattern
module fsm_mealy_10101 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
`ifdef FSM10101_COUNT_EN
  output logic [CNT_W-1:0] det_count,
`endif
  output logic             data_out
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   bit_in;
  logic   hit;

  // An X or Z on the input is treated as 0 so it never reaches the state register.
  assign bit_in = (data_in === 1'b1);

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Mealy output; unused encodings fall back to S0 with no output.
  always_comb begin
    state_nxt = S0;
    hit       = 1'b0;
    case (state)
      S0: state_nxt = bit_in ? S1 : S0;
      S1: state_nxt = bit_in ? S1 : S2;
      S2: state_nxt = bit_in ? S3 : S0;
      S3: state_nxt = bit_in ? S1 : S4;
      S4: begin
        state_nxt = S0;
        hit       = bit_in;
      end
      default: begin
        state_nxt = S0;
        hit       = 1'b0;
      end
    endcase
  end

  assign data_out = hit;

`ifdef FSM10101_COUNT_EN
  // Detection counter, bumped on the edge that samples the fifth bit; holds at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_count <= '0;
    end else if (hit && (det_count != {CNT_W{1'b1}})) begin
      det_count <= det_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fsm_mealy_10101.sv
// tb_fsm_mealy_10101: directed vectors with hand-computed expectations for the
// 10101 detector, plus a random stretch against a small reference model.
// The counter test runs only when FSM10101_COUNT_EN is defined.
module tb_fsm_mealy_10101;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  logic data_in;
  logic data_out;
`ifdef FSM10101_COUNT_EN
  logic [CNT_W-1:0] det_count;
`endif

  int n_cmp;
  int n_mis;

  fsm_mealy_10101 #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
`ifdef FSM10101_COUNT_EN
    .det_count(det_count),
`endif
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit mid-cycle, check the combinational output, then let the edge consume it.
  task automatic send_bit(input string tag, input logic b, input logic exp);
    @(negedge clk);
    data_in = b;
    #2;
    chk(tag, {31'd0, data_out}, {31'd0, exp});
  endtask

  // Bits are given MSB first: bits[n-1] is the first bit sent.
  task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                         input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      send_bit($sformatf("%s[%0d]", tag, i + 1), bits[n-1-i], exp[n-1-i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_in = 1'b0;
    rst     = 1'b0;
    #2;
    chk("rst_dout", {31'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int  m_state;
  logic m_out;

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    rst     = 1'b0;
    data_in = 1'b0;
    #2;
    chk("por_dout", {31'd0, data_out}, 32'd0);
    data_in = 1'b1;
    #1;
    chk("por_dout_in1", {31'd0, data_out}, 32'd0);
`ifdef FSM10101_COUNT_EN
    chk("por_count", {30'd0, det_count}, 32'd0);
`endif
    data_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Basic detection, pulse only on bit 5.
    run_seq("basic", 10, 16'b1010110011, 16'b0000100000);

    // Non-overlap, then continue from where that leaves the machine.
    do_reset();
    run_seq("novl", 9, 16'b101010101, 16'b000010000);
    run_seq("novl2", 10, 16'b1010110101, 16'b0000100001);

    // Leading extra 1, then recovery from S3 on a 1.
    do_reset();
    run_seq("lead1", 6, 16'b110101, 16'b000001);
    run_seq("recov", 8, 16'b10110101, 16'b00000001);

    // Reset in the middle of a partial match.
    do_reset();
    run_seq("mid", 4, 16'b1010, 16'b0000);
    @(negedge clk);
    #1;
    rst     = 1'b0;
    data_in = 1'b1;
    #1;
    chk("mid_rst_dout", {31'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_seq("post_rst", 5, 16'b10101, 16'b00001);

    // An unknown input in S4 must not complete the pattern.
    do_reset();
    run_seq("xin_pre", 4, 16'b1010, 16'b0000);
    send_bit("xin_s4", 1'bx, 1'b0);
    run_seq("xin_post", 5, 16'b10101, 16'b00001);

`ifdef FSM10101_COUNT_EN
    do_reset();
    chk("cnt_rst", {30'd0, det_count}, 32'd0);
    for (int g = 0; g < 4; g++) begin
      run_seq($sformatf("cnt_grp%0d", g), 5, 16'b10101, 16'b00001);
      @(posedge clk);
      #1;
      chk($sformatf("cnt_val%0d", g), {30'd0, det_count}, (g < 3) ? g + 1 : 3);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cnt_clear", {30'd0, det_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    // Random bits against a reference model of the transition table.
    do_reset();
    m_state = 0;
    for (int i = 0; i < 50; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      m_out = (m_state == 4) && b;
      send_bit($sformatf("rand[%0d]", i), b, m_out);
      case (m_state)
        0: m_state = b ? 1 : 0;
        1: m_state = b ? 1 : 2;
        2: m_state = b ? 3 : 0;
        3: m_state = b ? 1 : 4;
        default: m_state = 0;
      endcase
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fsm_mealy_10101.md
FSM_MEALY_10101 -- requirements
Module: fsm_mealy_10101

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the detection counter; used only when FSM10101_COUNT_EN is defined.
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port data_in, input, 1: serial bit stream, one bit consumed per rising clk edge.
REQ-005 The block SHALL have port data_out, output, 1: Mealy detect flag, high while the bit completing 10101 is present on data_in.
REQ-006 The block SHALL have port det_count, output, CNT_W: number of detections since reset; present only with FSM10101_COUNT_EN.

Function
REQ-007 The block SHALL hold a 5-state machine: S0 idle, S1 "1", S2 "10", S3 "101", S4 "1010"; encoding is free.
REQ-008 State SHALL advance only on rising clk, using the data_in value sampled at that edge.
REQ-009 Transitions for data_in=0/1 SHALL be: S0->S0/S1, S1->S2/S1, S2->S0/S3, S3->S4/S1, S4->S0/S0.
REQ-010 The machine SHALL detect non-overlapping sequences: after a detection it restarts from S0, so a detected sequence shares no bits with the next one.
REQ-011 data_out SHALL be combinational: data_out = 1 exactly when state==S4 and data_in==1, else 0; there is no register delay.
REQ-012 The detection SHALL be counted at the clk edge that leaves S4 on data_in=1, i.e. the edge that samples the fifth bit.
REQ-013 data_in SHALL be treated as 0 in any state when it is X or Z, so that no X reaches the state register.
REQ-014 Unreachable state encodings SHALL return to S0 on the next edge with data_out=0.

Reset
REQ-015 While rst=0, state SHALL be S0 immediately without waiting for a clock, data_out SHALL be 0 and det_count SHALL be 0.
REQ-016 Assertion of rst mid-sequence SHALL discard all partial progress.
REQ-017 The first edge after rst rises SHALL process data_in from S0.

Configuration
REQ-018 With macro FSM10101_COUNT_EN defined, det_count SHALL exist and increment by 1 per detection, saturating at 2^CNT_W-1 with no wrap.
REQ-019 Without FSM10101_COUNT_EN, det_count and its logic SHALL be absent, and detection behaviour SHALL be identical to the counter build.

Verification
REQ-020 Bench SHALL run: reset, then bits 1,0,1,0,1,1,0,0,1,1 -> data_out=1 only during the 5th bit; 0 for all other bits.
REQ-021 Bench SHALL run: bits 1,0,1,0,1,0,1,0,1 -> exactly one pulse, at bit 5; bits 7 and 9 give 0 (non-overlap). Then bits 1,0,1,0,1,1,0,1,0,1 -> pulses at bits 5 and 10.
REQ-022 Bench SHALL run: bits 1,1,0,1,0,1 -> pulse at bit 6. Then bits 1,0,1,1,0,1,0,1 -> pulse at bit 8 (recovery S3->S1).
REQ-023 Bench SHALL run: bits 1,0,1,0, then rst=0 between edges, then rst=1, then data_in=1 -> data_out=0; state S0 immediately at rst fall.
REQ-024 Bench SHALL run, with FSM10101_COUNT_EN and CNT_W=2: 4 back-to-back 10101 groups -> det_count goes 1,2,3,3, and rst=0 clears det_count to 0.
REQ-025 Bench SHALL run: 50 random bits, checked against a reference model of REQ-009 to REQ-011 every cycle -> zero mismatches.
